// File: rtl/onehot_updown_counter_pkg.sv
// Shared constants and helpers for the one-hot up/down ring counter.
// The reset state is bit 0 set, and the counter steps in one of two directions.
package onehot_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Bit position that is set after reset and after illegal-state recovery.
    localparam int RESET_BIT = 0;

    function automatic int idx_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/onehot_updown_counter_if.sv
// Command and status bundle for the one-hot up/down counter.
// The slave modport belongs to the counter. The master modport belongs to the controlling logic.
interface onehot_updown_counter_if
    import onehot_pkg::*;
#(
    parameter int WIDTH = 3
);
    localparam int IDXW = idx_width(WIDTH);

    logic             enable;
    logic             dir;
    logic             load;
    logic [IDXW-1:0]  load_idx;
    logic [WIDTH-1:0] q;
    logic [IDXW-1:0]  idx;
    logic             wrap;
    logic             err;

    modport master (
        output enable, dir, load, load_idx,
        input  q, idx, wrap, err
    );

    modport slave (
        input  enable, dir, load, load_idx,
        output q, idx, wrap, err
    );

endinterface

// File: rtl/onehot_updown_counter_encoder.sv
// Combinational one-hot to binary encoder.
// valid_o is high only when exactly one bit of the input is set.
module onehot_encoder
    import onehot_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int IDXW  = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot_i,
    output logic [IDXW-1:0]  idx_o,
    output logic             valid_o
);

    // NOTE: idx_o gets a default before the loop; without it a partial
    // assignment path would infer a latch.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | IDXW'(i);
            end
        end
    end

    assign valid_o = ($countones(onehot_i) == 1);

endmodule

// File: rtl/onehot_updown_counter.sv
// One-hot ring counter with the following features: up/down stepping, parallel load,
// a registered binary index, and self-recovery from non-one-hot states.
module onehot_updown_counter
    import onehot_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    onehot_updown_counter_if.slave  bus
);

    localparam int IDXW = idx_width(WIDTH);
    localparam logic [WIDTH-1:0] RESET_STATE = WIDTH'(1) << RESET_BIT;

    logic [WIDTH-1:0] ring_q, ring_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             cur_valid;
    logic [IDXW-1:0]  cur_idx;
    logic             nxt_valid;

    onehot_encoder #(.WIDTH(WIDTH), .IDXW(IDXW)) u_cur_enc (
        .onehot_i (ring_q),
        .idx_o    (cur_idx),
        .valid_o  (cur_valid)
    );

    onehot_encoder #(.WIDTH(WIDTH), .IDXW(IDXW)) u_nxt_enc (
        .onehot_i (ring_d),
        .idx_o    (idx_d),
        .valid_o  (nxt_valid)
    );

    // Priority: load > illegal-state recovery > step > hold.
    always_comb begin
        ring_d = ring_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (bus.load) begin
            if (int'(bus.load_idx) < WIDTH) begin
                ring_d = WIDTH'(1) << bus.load_idx;
            end else begin
                err_d = 1'b1;
            end
        end else if (!cur_valid) begin
            ring_d = RESET_STATE;
            err_d  = 1'b1;
        end else if (bus.enable) begin
            if (bus.dir == DIR_UP) begin
                ring_d = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
                wrap_d = ring_q[WIDTH-1];
            end else begin
                ring_d = {ring_q[0], ring_q[WIDTH-1:1]};
                wrap_d = ring_q[0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            ring_q <= RESET_STATE;
            idx_q  <= IDXW'(RESET_BIT);
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ring_q <= ring_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign bus.q    = ring_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
    assign bus.err  = err_q;

    // The current index and the next-state validity are unused at the ports.
    // They are kept for visibility in debug.
    logic unused_dbg;
    assign unused_dbg = ^{cur_idx, nxt_valid};

endmodule

// File: tb/tb_onehot_updown_counter.sv
// Directed bench for onehot_updown_counter with WIDTH=3.
// Each task drives one scenario and compares {q, idx, wrap, err} against hand-computed values.
module tb_onehot_updown_counter;

    localparam int WIDTH = 3;

    logic clock = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clock = ~clock;

    onehot_updown_counter_if #(.WIDTH(WIDTH)) bus ();

    onehot_updown_counter #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Drive on the negedge, let one posedge pass, then sample on the next negedge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic rst, input logic ld, input logic [1:0] li,
                         input logic en, input logic dr);
        reset        = rst;
        bus.load     = ld;
        bus.load_idx = li;
        bus.enable   = en;
        bus.dir      = dr;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        drive(1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
        tick();
        obs = {bus.q, bus.idx, bus.wrap, bus.err};
        total_cnt++;
        if (obs !== 7'b001_00_0_0)
            $display("FAIL reset: got q=%b idx=%0d wrap=%b err=%b, want q=001 idx=0 wrap=0 err=0",
                     bus.q, bus.idx, bus.wrap, bus.err);
        else pass_cnt++;
    endtask

    task automatic test_count_up();
        logic [6:0] exp_v [4];
        logic [6:0] obs;
        exp_v = '{7'b010_01_0_0, 7'b100_10_0_0, 7'b001_00_1_0, 7'b010_01_0_0};
        drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = {bus.q, bus.idx, bus.wrap, bus.err};
            total_cnt++;
            if (obs !== exp_v[i])
                $display("FAIL count_up[%0d]: got %b_%b_%b_%b, want %b", i,
                         bus.q, bus.idx, bus.wrap, bus.err, exp_v[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_count_down();
        logic [6:0] exp_v [5];
        logic [6:0] obs;
        // Load position 0, step down three times, then take one up step.
        exp_v = '{7'b001_00_0_0, 7'b100_10_1_0, 7'b010_01_0_0, 7'b001_00_0_0, 7'b010_01_0_0};
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
            else if (i == 4) drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
            else             drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
            tick();
            obs = {bus.q, bus.idx, bus.wrap, bus.err};
            total_cnt++;
            if (obs !== exp_v[i])
                $display("FAIL count_down[%0d]: got %b_%b_%b_%b, want %b", i,
                         bus.q, bus.idx, bus.wrap, bus.err, exp_v[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_load();
        logic [6:0] exp_v [5];
        logic [6:0] obs;
        // Load 0, load 2 while enabled, load out-of-range 3, hold, hold.
        exp_v = '{7'b001_00_0_0, 7'b100_10_0_0, 7'b100_10_0_1, 7'b100_10_0_0, 7'b100_10_0_0};
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
                1:       drive(1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
                2:       drive(1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
                default: drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
            endcase
            tick();
            obs = {bus.q, bus.idx, bus.wrap, bus.err};
            total_cnt++;
            if (obs !== exp_v[i])
                $display("FAIL load[%0d]: got %b_%b_%b_%b, want %b", i,
                         bus.q, bus.idx, bus.wrap, bus.err, exp_v[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_illegal();
        logic [2:0] bad [2];
        logic [6:0] obs;
        bad = '{3'b011, 3'b000};
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
            force dut.ring_q = bad[k];
            #1;
            release dut.ring_q;
            tick();
            obs = {bus.q, bus.idx, bus.wrap, bus.err};
            total_cnt++;
            if (obs !== 7'b001_00_0_1)
                $display("FAIL illegal_recover[%b]: got %b_%b_%b_%b, want 0010001", bad[k],
                         bus.q, bus.idx, bus.wrap, bus.err);
            else pass_cnt++;
            // After recovery, the counter steps normally and err clears.
            tick();
            obs = {bus.q, bus.idx, bus.wrap, bus.err};
            total_cnt++;
            if (obs !== 7'b010_01_0_0)
                $display("FAIL illegal_resume[%b]: got %b_%b_%b_%b, want 0100100", bad[k],
                         bus.q, bus.idx, bus.wrap, bus.err);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midcount();
        logic [6:0] exp_v [3];
        logic [6:0] obs;
        exp_v = '{7'b100_10_0_0, 7'b001_00_0_0, 7'b010_01_0_0};
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       drive(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
                1:       drive(1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
                default: drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
            endcase
            tick();
            obs = {bus.q, bus.idx, bus.wrap, bus.err};
            total_cnt++;
            if (obs !== exp_v[i])
                $display("FAIL reset_midcount[%0d]: got %b_%b_%b_%b, want %b", i,
                         bus.q, bus.idx, bus.wrap, bus.err, exp_v[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clock);
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_illegal();
        test_reset_midcount();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/onehot_updown_counter.md
Name: onehot_updown_counter

Overview:
Parameterised one-hot ring counter that steps up or down on command, with parallel load and a binary index output.
- Detects illegal (non-one-hot) state and self-recovers to a known state.
- Sits beside the existing three-stage one-hot up counter. It supplies reverse-direction sequencing and a binary view of the state to downstream logic and LED displays.

Parameters:
WIDTH, 3, number of one-hot stages (legal range: 2 or more)
IDXW, $clog2(WIDTH), width of the binary index; derived, not to be overridden

Ports:
clock  input  1  single system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  step the counter by one position this cycle
dir  input  1  0 = up (bit i -> bit i+1), 1 = down (bit i -> bit i-1)
load  input  1  parallel-load request
load_idx  input  IDXW  binary position to load
q  output  WIDTH  registered one-hot state
idx  output  IDXW  registered binary index of the set bit in q
wrap  output  1  registered one-cycle pulse: the last step wrapped around the ring
err  output  1  registered one-cycle pulse: illegal state recovered, or out-of-range load

Behaviour:
- Reset, sampled at the rising clock edge while reset=1: q=1 (bit 0), idx=0, wrap=0, err=0. Reset overrides every other input.
- All outputs are registered. q and idx always update on the same edge and are mutually consistent.
- Priority per edge: reset > load > illegal-state recovery > enable > hold.
- Load:
  - load=1 with load_idx < WIDTH: q <= 1<<load_idx, idx <= load_idx, wrap=0, err=0.
  - load=1 with load_idx >= WIDTH: q and idx hold, err=1 for one cycle, wrap=0.
- Illegal state: q has zero bits set or more than one bit set.
  - Checked combinationally on the current q.
  - If illegal at an edge with reset=0 and load=0: q <= 1, idx <= 0, err=1 for one cycle, wrap=0. enable is ignored on that edge.
- Step (enable=1, q legal, no load):
  - dir=0: rotate left. Bit WIDTH-1 wraps to bit 0; wrap=1 on that step.
  - dir=1: rotate right. Bit 0 wraps to bit WIDTH-1; wrap=1 on that step.
  - Otherwise wrap=0.
- Hold (enable=0, no load, q legal): q and idx unchanged; wrap=0, err=0.
- wrap and err are high in the same cycle as the q value they describe. They are never high for more than one cycle per event.
- Latency: one clock from input sample to q, idx, wrap and err.
- dir is sampled only when stepping. A dir change between steps takes effect on the next step with no bubble.

Decomposition:
- Shared package onehot_pkg:
  - DIR_UP=1'b0 and DIR_DOWN=1'b1 constants.
  - Reset-state constant (bit 0).
  - Index-width helper function.
- One sub-module, onehot_encoder: combinational one-hot to binary conversion plus a single-bit "valid" output (exactly one bit set).
  - Used once on current q for the legality check.
  - Used once on next-state q to produce the registered idx.

Test Plan:
1. Assert reset for 1 cycle with load=1, enable=1 -> q=001, idx=0, wrap=0, err=0 on the following cycle.
2. enable=1, dir=0, 4 clocks from 001 -> q=010,100,001,010; idx=1,2,0,1; wrap=1 only on the q=001 cycle.
3. enable=1, dir=1, 3 clocks from 001 -> q=100,010,001; idx=2,1,0; wrap=1 only on the q=100 cycle. Then flip dir=0 for one step -> q=010, wrap=0.
4. load=1, load_idx=2, enable=1, dir=0 in the same cycle from 001 -> q=100, idx=2, wrap=0, err=0. Then load_idx=3 -> q stays 100, idx stays 2, err=1 for exactly one cycle.
5. Deposit q=011 (bench force/release), enable=1 -> next edge q=001, idx=0, err=1, wrap=0. Repeat with deposited q=000 -> same response.
6. Mid-count at q=100 with enable=1, raise reset for one edge while load=1, load_idx=1 -> q=001, idx=0, wrap=0, err=0. Release reset; counting resumes 010 on the next enabled edge.
